// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable UART timing source.
//
// Divides clk into a one-cycle sample_tick at OVERSAMPLE x baud and a one-cycle
// baud_tick on the last sample_tick of every baud period. The sample period is
// div_reg+1 clk plus a fractional part frac_reg/2^FRAC_W clk, spread by stretching
// individual periods by one clk whenever the fractional accumulator carries.
// Ticks are clock enables, never clocks.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset       in   asynchronous active-low reset
//   en          in   1 = run, 0 = idle (counters held at zero)
//   resync      in   synchronous restart of sample/baud phase
//   div_load    in   capture div_in/frac_in on this edge
//   div_in      in   new integer divisor
//   frac_in     in   new fractional divisor
//   sample_tick out  one-cycle pulse per sample period
//   baud_tick   out  one-cycle pulse on the last sample_tick of a baud period
//   baud_level  out  toggles on every baud_tick
//   phase       out  sample index within the baud period
module baud_tick_gen #(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned OVERSAMPLE   = 16,  // power of two, >= 2
  parameter int unsigned DEFAULT_DIV  = 15,
  parameter int unsigned DEFAULT_FRAC = 0,
  localparam int unsigned PH_W        = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              resync,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              sample_tick,
  output logic              baud_tick,
  output logic              baud_level,
  output logic [PH_W-1:0]   phase
);

  // Counter is one bit wider than the divisor so div_reg + stretch cannot wrap.
  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] facc_q, facc_d;
  logic              stretch_q, stretch_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              sample_tick_q, sample_tick_d;
  logic              baud_tick_q, baud_tick_d;
  logic              baud_level_q, baud_level_d;

  // Active divisor, shadow copy and pending flag for glitch-free reload.
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
  logic              pend_q, pend_d;

  logic [DIV_W:0]    limit;
  logic              wrap;
  logic [FRAC_W:0]   facc_sum;
  logic              apply;

  assign limit    = {1'b0, div_q} + {{DIV_W{1'b0}}, stretch_q};
  assign wrap     = (cnt_q == limit);
  // Carry uses the frac value that governed the period now ending.
  assign facc_sum = {1'b0, facc_q} + {1'b0, frac_q};

  // Counter, phase and tick generation.
  always_comb begin
    cnt_d         = cnt_q;
    facc_d        = facc_q;
    stretch_d     = stretch_q;
    phase_d       = phase_q;
    sample_tick_d = 1'b0;
    baud_tick_d   = 1'b0;
    baud_level_d  = baud_level_q;
    apply         = 1'b0;

    if (resync || !en) begin
      // Restart from a clean phase; ticks suppressed even if cnt == limit.
      cnt_d     = '0;
      facc_d    = '0;
      stretch_d = 1'b0;
      phase_d   = '0;
      apply     = 1'b1;
    end else if (wrap) begin
      cnt_d               = '0;
      sample_tick_d       = 1'b1;
      {stretch_d, facc_d} = facc_sum;
      phase_d             = phase_q + 1'b1;
      // OVERSAMPLE is a power of two, so the last phase is all ones.
      if (&phase_q) begin
        baud_tick_d  = 1'b1;
        baud_level_d = ~baud_level_q;
      end
      apply = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divisor reload: a load only takes effect at a period boundary (wrap,
  // resync or idle). A load coinciding with that boundary wins over the shadow.
  always_comb begin
    div_d     = div_q;
    frac_d    = frac_q;
    div_sh_d  = div_sh_q;
    frac_sh_d = frac_sh_q;
    pend_d    = pend_q;

    if (div_load) begin
      div_sh_d  = div_in;
      frac_sh_d = frac_in;
    end

    if (apply) begin
      pend_d = 1'b0;
      if (div_load) begin
        div_d  = div_in;
        frac_d = frac_in;
      end else if (pend_q) begin
        div_d  = div_sh_q;
        frac_d = frac_sh_q;
      end
    end else if (div_load) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      facc_q        <= '0;
      stretch_q     <= 1'b0;
      phase_q       <= '0;
      sample_tick_q <= 1'b0;
      baud_tick_q   <= 1'b0;
      baud_level_q  <= 1'b0;
      div_q         <= DIV_W'(DEFAULT_DIV);
      frac_q        <= FRAC_W'(DEFAULT_FRAC);
      div_sh_q      <= DIV_W'(DEFAULT_DIV);
      frac_sh_q     <= FRAC_W'(DEFAULT_FRAC);
      pend_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      facc_q        <= facc_d;
      stretch_q     <= stretch_d;
      phase_q       <= phase_d;
      sample_tick_q <= sample_tick_d;
      baud_tick_q   <= baud_tick_d;
      baud_level_q  <= baud_level_d;
      div_q         <= div_d;
      frac_q        <= frac_d;
      div_sh_q      <= div_sh_d;
      frac_sh_q     <= frac_sh_d;
      pend_q        <= pend_d;
    end
  end

  assign sample_tick = sample_tick_q;
  assign baud_tick   = baud_tick_q;
  assign baud_level  = baud_level_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Testbench for baud_tick_gen: a vector table, directed multi-cycle sequences
// and randomized traffic, all compared against a countdown-style reference model.
module tb_baud_tick_gen;

  localparam int unsigned DW      = 10;
  localparam int unsigned FW      = 4;
  localparam int unsigned OS      = 16;
  localparam int unsigned DEF_DIV = 15;
  localparam int unsigned PW      = 4;
  localparam int unsigned MAX_DIV = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          resync = 1'b0;
  logic          div_load = 1'b0;
  logic [DW-1:0] div_in = '0;
  logic [FW-1:0] frac_in = '0;
  logic          sample_tick;
  logic          baud_tick;
  logic          baud_level;
  logic [PW-1:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  baud_tick_gen #(
    .DIV_W       (DW),
    .FRAC_W      (FW),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (DEF_DIV),
    .DEFAULT_FRAC(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .resync     (resync),
    .div_load   (div_load),
    .div_in     (div_in),
    .frac_in    (frac_in),
    .sample_tick(sample_tick),
    .baud_tick  (baud_tick),
    .baud_level (baud_level),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference model: counts down the edges remaining in the current period and
  // derives the next period length as div+1 plus the fractional carry.
  int m_rem, m_acc, m_ph, m_div, m_frac, m_sdiv, m_sfrac, m_carry;
  bit m_pend, m_st, m_bt, m_lvl;

  task automatic model_reset();
    m_div  = DEF_DIV;
    m_frac = 0;
    m_sdiv = DEF_DIV;
    m_sfrac = 0;
    m_pend = 0;
    m_rem  = DEF_DIV + 1;
    m_acc  = 0;
    m_ph   = 0;
    m_st   = 0;
    m_bt   = 0;
    m_lvl  = 0;
  endtask

  task automatic model_apply(input bit l, input int d, input int f);
    if (l) begin
      m_div  = d;
      m_frac = f;
    end else if (m_pend) begin
      m_div  = m_sdiv;
      m_frac = m_sfrac;
    end
    m_pend = 0;
  endtask

  task automatic model_step(input bit e, input bit r, input bit l, input int d, input int f);
    if (r || !e) begin
      model_apply(l, d, f);
      m_acc = 0;
      m_ph  = 0;
      m_st  = 0;
      m_bt  = 0;
      m_rem = m_div + 1;
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_acc   = m_acc + m_frac;
        m_carry = m_acc / (1 << FW);
        m_acc   = m_acc % (1 << FW);
        model_apply(l, d, f);
        m_rem = m_div + 1 + m_carry;
        m_st  = 1;
        m_bt  = (m_ph == OS - 1);
        if (m_bt) m_lvl = !m_lvl;
        m_ph = (m_ph + 1) % OS;
      end else begin
        m_st = 0;
        m_bt = 0;
        if (l) begin
          m_pend  = 1;
          m_sdiv  = d;
          m_sfrac = f;
        end
      end
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit e, input bit r, input bit l, input int d, input int f);
    logic [6:0] exp_v;
    en       = e;
    resync   = r;
    div_load = l;
    div_in   = DW'(d);
    frac_in  = FW'(f);
    @(posedge clk);
    model_step(e, r, l, d, f);
    #1;
    exp_v = {m_st, m_bt, m_lvl, PW'(m_ph)};
    check("model", 32'({sample_tick, baud_tick, baud_level, phase}), 32'(exp_v));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // Run with en=1 until sample_tick is seen; n = edges taken.
  task automatic wait_tick(input int max_edges, output int n);
    n = 0;
    for (int i = 0; i < max_edges; i++) begin
      step(1, 0, 0, 0, 0);
      n++;
      if (sample_tick) break;
    end
    if (!sample_tick) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_tick: got no sample_tick in %0d edges, required one", max_edges);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    en       = 1'b0;
    resync   = 1'b0;
    div_load = 1'b0;
    #1;
    check("rst_sample_tick", 32'(sample_tick), 0);
    check("rst_baud_tick", 32'(baud_tick), 0);
    check("rst_baud_level", 32'(baud_level), 0);
    check("rst_phase", 32'(phase), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit en;
    bit rs;
    bit ld;
    int div;
    int frac;
    bit exp_st;
    bit exp_bt;
    int exp_ph;
  } vec_t;

  vec_t vecs[18];
  int   n, total, cnt_st, cnt_bt, first_bt;

  initial begin
    vecs[0]  = '{0, 0, 1, 1, 0, 0, 0, 0};  // idle load applies at once
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 0, 0, 0, 0, 1, 0, 2};
    vecs[5]  = '{1, 1, 0, 0, 0, 0, 0, 0};  // resync mid-period
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{1, 1, 0, 0, 0, 0, 0, 0};  // resync exactly on cnt == limit
    vecs[10] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 0, 0};  // div = 0
    vecs[14] = '{1, 0, 0, 0, 0, 1, 0, 1};
    vecs[15] = '{1, 0, 0, 0, 0, 1, 0, 2};
    vecs[16] = '{1, 0, 0, 0, 0, 1, 0, 3};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0};

    #1;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].en, vecs[i].rs, vecs[i].ld, vecs[i].div, vecs[i].frac);
      check($sformatf("vec%0d", i), 32'({sample_tick, baud_tick, phase}),
            32'({vecs[i].exp_st, vecs[i].exp_bt, PW'(vecs[i].exp_ph)}));
    end

    // Defaults: sample every 16 clk, baud every 256 clk.
    do_reset();
    cnt_st   = 0;
    cnt_bt   = 0;
    first_bt = -1;
    for (int i = 1; i <= 512; i++) begin
      step(1, 0, 0, 0, 0);
      if (sample_tick) cnt_st++;
      if (baud_tick) begin
        cnt_bt++;
        if (first_bt < 0) first_bt = i;
      end
    end
    check("def_sample_count", 32'(cnt_st), 32);
    check("def_baud_count", 32'(cnt_bt), 2);
    check("def_first_baud_edge", 32'(first_bt), 256);

    // Fractional divisor 3 + 8/16: 16 periods in 72 clk.
    step(0, 0, 1, 3, 8);
    wait_tick(20, n);
    check("frac8_first_period", 32'(n), 4);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(20, n);
      total += n;
    end
    check("frac8_16_periods", 32'(total), 72);

    // Fractional divisor 3 + 1/16: one 5-clk period in 16.
    step(0, 0, 1, 3, 1);
    wait_tick(20, n);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(20, n);
      total += n;
    end
    check("frac1_16_periods", 32'(total), 65);

    // Mid-period load: current period keeps its length.
    step(0, 0, 1, 9, 0);
    run(5);
    step(1, 0, 1, 4, 0);
    wait_tick(20, n);
    check("load_mid_current", 32'(n + 6), 10);
    wait_tick(20, n);
    check("load_mid_next1", 32'(n), 5);
    wait_tick(20, n);
    check("load_mid_next2", 32'(n), 5);

    // Load on the wrap edge governs the very next period.
    step(0, 0, 1, 9, 0);
    run(9);
    step(1, 0, 1, 4, 0);
    check("load_wrap_tick", 32'(sample_tick), 1);
    wait_tick(20, n);
    check("load_wrap_next", 32'(n), 5);

    // Resync at phase 7, cnt 6.
    step(0, 0, 1, 9, 0);
    run(76);
    check("resync_pre_phase", 32'(phase), 7);
    step(1, 1, 0, 0, 0);
    check("resync_no_tick", 32'(sample_tick), 0);
    check("resync_phase0", 32'(phase), 0);
    wait_tick(20, n);
    check("resync_first_period", 32'(n), 10);
    check("resync_first_phase", 32'(phase), 1);
    cnt_bt = 0;
    for (int i = 0; i < 15; i++) begin
      wait_tick(20, n);
      if (baud_tick) cnt_bt++;
    end
    check("resync_baud_at_16th", 32'({cnt_bt[3:0], baud_tick}), 32'({4'd1, 1'b1}));

    // Idle mid-period.
    run(4);
    step(0, 0, 0, 0, 0);
    check("idle_ticks", 32'({sample_tick, baud_tick}), 0);
    check("idle_phase", 32'(phase), 0);

    // Reset mid-run discards a pending load.
    step(0, 0, 1, 9, 0);
    run(3);
    step(1, 0, 1, 2, 0);
    run(2);
    do_reset();
    wait_tick(40, n);
    check("reset_drops_pending", 32'(n), DEF_DIV + 1);

    // div = 0: sample_tick continuously high, baud every 16 clk.
    step(0, 0, 1, 0, 0);
    cnt_st = 0;
    cnt_bt = 0;
    for (int i = 0; i < 48; i++) begin
      step(1, 0, 0, 0, 0);
      if (sample_tick) cnt_st++;
      if (baud_tick) cnt_bt++;
    end
    check("div0_sample_count", 32'(cnt_st), 48);
    check("div0_baud_count", 32'(cnt_bt), 3);

    // Maximum divisor with maximum fraction: no counter overflow.
    step(0, 0, 1, MAX_DIV, 15);
    for (int i = 0; i < 4; i++) begin
      wait_tick(MAX_DIV + 10, n);
      check($sformatf("maxdiv_period%0d", i), 32'(n >= MAX_DIV + 1 && n <= MAX_DIV + 2), 1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
